// File: rtl/seq_trigger_mc.sv
// Multi-channel load_mem -> done sequence detector with a [WIN_MIN:WIN_MAX] acceptance
// window, stretched ready pulse, expiry timeout and a shared saturating match counter.
module seq_trigger_mc #(
  parameter int NUM_CH    = 4,
  parameter int WIN_MIN   = 0,
  parameter int WIN_MAX   = 5,
  parameter int PULSE_LEN = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] load_mem,
  input  logic [NUM_CH-1:0] done,
  output logic [NUM_CH-1:0] ready,
  output logic [NUM_CH-1:0] timeout,
  output logic [NUM_CH-1:0] armed,
  output logic [CNT_W-1:0]  match_count
);

  localparam int KW = 9;
  localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam int SW = CNT_W + $clog2(NUM_CH + 1) + 1;
  localparam logic [PW-1:0]    P_RELOAD = PW'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  if (NUM_CH < 1 || PULSE_LEN < 1 || WIN_MIN < 0 || WIN_MIN > WIN_MAX || WIN_MAX > 255)
  begin : g_param_err
    $error("seq_trigger_mc: illegal parameter combination");
  end

  logic [NUM_CH-1:0] load_q, load_d;
  logic [NUM_CH-1:0] arm_q, arm_d;
  logic [NUM_CH-1:0] ready_q, ready_d;
  logic [NUM_CH-1:0] timeout_q, timeout_d;
  logic [KW-1:0]     k_q [NUM_CH];
  logic [KW-1:0]     k_d [NUM_CH];
  logic [PW-1:0]     p_q [NUM_CH];
  logic [PW-1:0]     p_d [NUM_CH];
  logic [CNT_W-1:0]  count_q, count_d;

  logic [NUM_CH-1:0] rise, active, match, expire;
  int                k_eff [NUM_CH];
  logic [SW-1:0]     sum;

  always_comb begin
    load_d = load_mem;
    sum    = SW'(count_q);
    for (int i = 0; i < NUM_CH; i++) begin
      rise[i]   = load_mem[i] & ~load_q[i];
      active[i] = en & (arm_q[i] | rise[i]);
      // A rise restarts the window, so the rise clock itself is k = 0.
      k_eff[i]  = rise[i] ? 0 : int'(k_q[i]);
      match[i]  = active[i] & done[i] & (k_eff[i] >= WIN_MIN) & (k_eff[i] <= WIN_MAX);
      expire[i] = active[i] & ~match[i] & (k_eff[i] >= WIN_MAX);

      arm_d[i]     = active[i] & ~match[i] & ~expire[i];
      k_d[i]       = active[i] ? KW'(k_eff[i] + 1) : k_q[i];
      timeout_d[i] = expire[i];

      // A new match reloads the pulse so back-to-back pulses merge without a gap.
      if (match[i]) begin
        ready_d[i] = 1'b1;
        p_d[i]     = P_RELOAD;
      end else if (ready_q[i] && p_q[i] != '0) begin
        ready_d[i] = 1'b1;
        p_d[i]     = p_q[i] - PW'(1);
      end else begin
        ready_d[i] = 1'b0;
        p_d[i]     = '0;
      end

      sum = sum + SW'(match[i]);
    end
    count_d = (sum > SW'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_q    <= '0;
      arm_q     <= '0;
      ready_q   <= '0;
      timeout_q <= '0;
      count_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        k_q[i] <= '0;
        p_q[i] <= '0;
      end
    end else begin
      load_q    <= load_d;
      arm_q     <= arm_d;
      ready_q   <= ready_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
      for (int i = 0; i < NUM_CH; i++) begin
        k_q[i] <= k_d[i];
        p_q[i] <= p_d[i];
      end
    end
  end

  assign ready       = ready_q;
  assign timeout     = timeout_q;
  assign armed       = arm_q;
  assign match_count = count_q;

endmodule

// File: tb/tb_seq_trigger_mc.sv
// Directed bench for seq_trigger_mc: four instances (defaults, PULSE_LEN=3, WIN_MIN=2,
// CNT_W=2); each step drives one clock and checks the registered outputs of the next one.
module tb_seq_trigger_mc;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic [3:0] ld [4];
  logic [3:0] dn [4];

  logic [3:0]  rdy_a, tmo_a, arm_a, rdy_p, tmo_p, arm_p;
  logic [3:0]  rdy_m, tmo_m, arm_m, rdy_c, tmo_c, arm_c;
  logic [15:0] cnt_a, cnt_p, cnt_m;
  logic [1:0]  cnt_c;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    int          d;
    logic [27:0] exp;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  seq_trigger_mc u_a (
    .clk(clk), .rst(rst), .en(en), .load_mem(ld[0]), .done(dn[0]),
    .ready(rdy_a), .timeout(tmo_a), .armed(arm_a), .match_count(cnt_a)
  );

  seq_trigger_mc #(.PULSE_LEN(3)) u_p (
    .clk(clk), .rst(rst), .en(en), .load_mem(ld[1]), .done(dn[1]),
    .ready(rdy_p), .timeout(tmo_p), .armed(arm_p), .match_count(cnt_p)
  );

  seq_trigger_mc #(.WIN_MIN(2)) u_m (
    .clk(clk), .rst(rst), .en(en), .load_mem(ld[2]), .done(dn[2]),
    .ready(rdy_m), .timeout(tmo_m), .armed(arm_m), .match_count(cnt_m)
  );

  seq_trigger_mc #(.CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .en(en), .load_mem(ld[3]), .done(dn[3]),
    .ready(rdy_c), .timeout(tmo_c), .armed(arm_c), .match_count(cnt_c)
  );

  function automatic logic [27:0] observe(input int d);
    case (d)
      0:       return {rdy_a, tmo_a, arm_a, cnt_a};
      1:       return {rdy_p, tmo_p, arm_p, cnt_p};
      2:       return {rdy_m, tmo_m, arm_m, cnt_m};
      3:       return {rdy_c, tmo_c, arm_c, 14'd0, cnt_c};
      default: return '0;
    endcase
  endfunction

  // Drive load/done of instance d for one clock; expect ready/timeout/armed/count after it.
  task automatic cyc(input string tag, input int d, input logic [3:0] l, input logic [3:0] n,
                     input logic [3:0] er, input logic [3:0] et, input logic [3:0] ea,
                     input logic [15:0] ec);
    exp_t        e;
    logic [27:0] obs;
    ld[d] = l;
    dn[d] = n;
    e.tag = tag;
    e.d   = d;
    e.exp = {er, et, ea, ec};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e   = sb.pop_front();
    obs = observe(e.d);
    tests++;
    assert (obs === e.exp) else begin
      fails++;
      $error("FAIL %s: observed ready/timeout/armed/count=%h/%h/%h/%h required %h/%h/%h/%h",
             e.tag, obs[27:24], obs[23:20], obs[19:16], obs[15:0],
             e.exp[27:24], e.exp[23:20], e.exp[19:16], e.exp[15:0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ld[i] = 4'h0;
      dn[i] = 4'h0;
    end
    for (int d = 0; d < 4; d++) cyc("reset", d, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'd0);
    rst = 1'b0;

    // ch0: rise, done three clocks later
    cyc("t1_rise",  0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 16'd0);
    cyc("t1_k1",    0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 16'd0);
    cyc("t1_k2",    0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 16'd0);
    cyc("t1_done",  0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 16'd1);
    cyc("t1_after", 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'd1);

    // ch1: rise, no done -> armed five clocks, then one timeout clock
    cyc("t2_rise",  0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 16'd1);
    for (int i = 0; i < 4; i++) cyc("t2_armed", 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 16'd1);
    cyc("t2_tmo",   0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 16'd1);
    cyc("t2_after", 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'd1);

    // ch2 boundaries: done on the rise clock, at k=5, and at k=6
    cyc("b_same",   0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 16'd2);
    cyc("b_same2",  0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'd2);
    cyc("b5_rise",  0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h4, 16'd2);
    for (int i = 0; i < 4; i++) cyc("b5_armed", 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 16'd2);
    cyc("b5_done",  0, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0, 16'd3);
    cyc("b5_after", 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'd3);
    cyc("b6_rise",  0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h4, 16'd3);
    for (int i = 0; i < 4; i++) cyc("b6_armed", 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 16'd3);
    cyc("b6_tmo",   0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 16'd3);
    cyc("b6_late",  0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 16'd3);

    // all four channels match on the same clock
    cyc("all_match", 0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 16'd7);
    cyc("all_after", 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'd7);

    // ch3 re-armed two clocks in: the first window must not time out
    cyc("ra_rise0", 0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h8, 16'd7);
    cyc("ra_gap",   0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 16'd7);
    cyc("ra_rise1", 0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h8, 16'd7);
    for (int i = 0; i < 4; i++) cyc("ra_armed", 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 16'd7);
    cyc("ra_tmo",   0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 16'd7);
    cyc("ra_after", 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'd7);

    // en low kills an open window silently and blocks arming
    cyc("en_rise",  0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 16'd7);
    cyc("en_k1",    0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 16'd7);
    en = 1'b0;
    cyc("en_off",   0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'd7);
    for (int i = 0; i < 4; i++) cyc("en_quiet", 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'd7);
    cyc("en_block", 0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 16'd7);
    cyc("en_block2", 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'd7);
    en = 1'b1;

    // WIN_MIN=2: early done ignored, later done matches
    cyc("m_rise",  2, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 16'd0);
    cyc("m_early", 2, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 16'd0);
    cyc("m_k2",    2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 16'd0);
    cyc("m_done",  2, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 16'd1);
    cyc("m_after", 2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'd1);

    // PULSE_LEN=3: matches two clocks apart merge into one five-clock pulse
    cyc("p_m0",   1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 16'd1);
    cyc("p_gap",  1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 16'd1);
    cyc("p_m1",   1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 16'd2);
    cyc("p_ext1", 1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 16'd2);
    cyc("p_ext2", 1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 16'd2);
    cyc("p_end",  1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'd2);

    // PULSE_LEN=3: arming while ready is high, then a later match
    cyc("pa_m",    1, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 16'd3);
    cyc("pa_gap",  1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 16'd3);
    cyc("pa_rise", 1, 4'h2, 4'h0, 4'h2, 4'h0, 4'h2, 16'd3);
    cyc("pa_k1",   1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 16'd3);
    cyc("pa_done", 1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 16'd4);
    cyc("pa_p2",   1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 16'd4);
    cyc("pa_p3",   1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 16'd4);
    cyc("pa_end",  1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'd4);

    // CNT_W=2: five matches saturate at 3
    cyc("c_m2",  3, 4'h3, 4'h3, 4'h3, 4'h0, 4'h0, 16'd2);
    cyc("c_gap", 3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'd2);
    cyc("c_m3",  3, 4'h7, 4'h7, 4'h7, 4'h0, 4'h0, 16'd3);
    cyc("c_sat", 3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'd3);

    // reset in the middle of an open window: everything clears, no late timeout
    cyc("rm_rise", 0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 16'd7);
    cyc("rm_k1",   0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 16'd7);
    rst = 1'b1;
    cyc("rm_rst",  0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) cyc("rm_quiet", 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
